// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL/ROR with valid/ready on both sides.
// Optional outZero/outCarry flags are built when SHIFTER_FLAGS_EN is defined.
module pipelined_shifter #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 1
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [WIDTH-1:0]         inData,
    input  logic [$clog2(WIDTH)-1:0] shAmt,
    input  logic [2:0]               shOp,
    input  logic                     shBit,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [WIDTH-1:0]         outData
`ifdef SHIFTER_FLAGS_EN
    ,
    output logic                     outZero,
    output logic                     outCarry
`endif
);

    localparam int AW = $clog2(WIDTH);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    logic             adv_s;
    logic [WIDTH-1:0] out_dat_q;
    logic             out_vld_q;
`ifdef SHIFTER_FLAGS_EN
    logic             out_zero_q;
    logic             out_cy_q;
`endif

    // SRA fills with the current MSB, which stays equal to the operand sign across stages.
    function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                     input logic [2:0]       op,
                                                     input logic             fill,
                                                     input int               sh);
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] fill_v;
        logic [WIDTH-1:0] sign_v;
        logic [WIDTH-1:0] r;
        ones   = {WIDTH{1'b1}};
        fill_v = {WIDTH{fill}};
        sign_v = {WIDTH{d[WIDTH-1]}};
        case (op)
            OP_SLL:  r = (d << sh) | (fill_v & ~(ones << sh));
            OP_SRL:  r = (d >> sh) | (fill_v & ~(ones >> sh));
            OP_SRA:  r = (d >> sh) | (sign_v & ~(ones >> sh));
            OP_ROL:  r = (d << sh) | (d >> (WIDTH - sh));
            OP_ROR:  r = (d >> sh) | (d << (WIDTH - sh));
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef SHIFTER_FLAGS_EN
    function automatic logic carry_out(input logic [WIDTH-1:0] d,
                                       input logic [2:0]       op,
                                       input int               sh);
        logic [WIDTH-1:0] rot_l;
        logic [WIDTH-1:0] rot_r;
        logic             c;
        rot_l = (d << sh) | (d >> (WIDTH - sh));
        rot_r = (d >> sh) | (d << (WIDTH - sh));
        case (op)
            OP_SLL, OP_ROL:         c = rot_l[0];
            OP_SRL, OP_SRA, OP_ROR: c = rot_r[WIDTH-1];
            default:                c = 1'b0;
        endcase
        return c;
    endfunction
`endif

    assign adv_s    = !out_vld_q || outReady;
    assign inReady  = adv_s;
    assign outValid = out_vld_q;
    assign outData  = out_dat_q;
`ifdef SHIFTER_FLAGS_EN
    assign outZero  = out_zero_q;
    assign outCarry = out_cy_q;
`endif

    for (genvar k = 0; k < AW; k++) begin : g_stage
        // Amount bits already consumed by earlier stages are dropped.
        logic [WIDTH-1:0] src_dat_s;
        logic [2:0]       src_op_s;
        logic             src_fill_s;
        logic             src_vld_s;
        logic [AW-1:k]    src_amt_s;
        logic [WIDTH-1:0] nxt_dat_s;
`ifdef SHIFTER_FLAGS_EN
        logic             src_cy_s;
        logic             nxt_cy_s;
`endif

        if (k == 0) begin : g_in
            assign src_dat_s  = inData;
            assign src_op_s   = shOp;
            assign src_fill_s = shBit;
            assign src_vld_s  = inValid;
            assign src_amt_s  = shAmt;
`ifdef SHIFTER_FLAGS_EN
            assign src_cy_s   = 1'b0;
`endif
        end else if (PIPE != 0) begin : g_reg
            logic [WIDTH-1:0] dat_q;
            logic [2:0]       op_q;
            logic             fill_q;
            logic             vld_q;
            logic [AW-1:k]    amt_q;
`ifdef SHIFTER_FLAGS_EN
            logic             cy_q;
`endif
            // Inter-stage register; the whole pipe advances or holds together.
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    dat_q  <= {WIDTH{1'b0}};
                    op_q   <= 3'b000;
                    fill_q <= 1'b0;
                    vld_q  <= 1'b0;
                    amt_q  <= {(AW-k){1'b0}};
`ifdef SHIFTER_FLAGS_EN
                    cy_q   <= 1'b0;
`endif
                end else if (adv_s) begin
                    dat_q  <= g_stage[k-1].nxt_dat_s;
                    op_q   <= g_stage[k-1].src_op_s;
                    fill_q <= g_stage[k-1].src_fill_s;
                    vld_q  <= g_stage[k-1].src_vld_s;
                    amt_q  <= g_stage[k-1].src_amt_s[AW-1:k];
`ifdef SHIFTER_FLAGS_EN
                    cy_q   <= g_stage[k-1].nxt_cy_s;
`endif
                end
            end
            assign src_dat_s  = dat_q;
            assign src_op_s   = op_q;
            assign src_fill_s = fill_q;
            assign src_vld_s  = vld_q;
            assign src_amt_s  = amt_q;
`ifdef SHIFTER_FLAGS_EN
            assign src_cy_s   = cy_q;
`endif
        end else begin : g_comb
            assign src_dat_s  = g_stage[k-1].nxt_dat_s;
            assign src_op_s   = g_stage[k-1].src_op_s;
            assign src_fill_s = g_stage[k-1].src_fill_s;
            assign src_vld_s  = g_stage[k-1].src_vld_s;
            assign src_amt_s  = g_stage[k-1].src_amt_s[AW-1:k];
`ifdef SHIFTER_FLAGS_EN
            assign src_cy_s   = g_stage[k-1].nxt_cy_s;
`endif
        end

        // Log-stage k: shift by 2^k when its amount bit is set.
        always_comb begin
            if (src_amt_s[k]) begin
                nxt_dat_s = stage_shift(src_dat_s, src_op_s, src_fill_s, 32'sd1 << k);
`ifdef SHIFTER_FLAGS_EN
                nxt_cy_s  = carry_out(src_dat_s, src_op_s, 32'sd1 << k);
`endif
            end else begin
                nxt_dat_s = src_dat_s;
`ifdef SHIFTER_FLAGS_EN
                nxt_cy_s  = src_cy_s;
`endif
            end
        end
    end

    // Output register: last stage result, held while the consumer stalls.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_dat_q  <= {WIDTH{1'b0}};
            out_vld_q  <= 1'b0;
`ifdef SHIFTER_FLAGS_EN
            out_zero_q <= 1'b0;
            out_cy_q   <= 1'b0;
`endif
        end else if (adv_s) begin
            out_dat_q  <= g_stage[AW-1].nxt_dat_s;
            out_vld_q  <= g_stage[AW-1].src_vld_s;
`ifdef SHIFTER_FLAGS_EN
            out_zero_q <= (g_stage[AW-1].nxt_dat_s == {WIDTH{1'b0}});
            out_cy_q   <= g_stage[AW-1].nxt_cy_s;
`endif
        end
    end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the 32-bit combinational shifter in the ALU.
- Supports any power-of-two WIDTH and five shift/rotate modes, including arithmetic right shift and rotates.
- Uses valid/ready handshakes on both sides with full backpressure and sustains one operation per cycle.
- Sits between the ALU operand registers and the result mux.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two, range 4..128; AW = log2(WIDTH) is a localparam.
- PIPE, 1, 1 = register after every log-stage (latency AW cycles); 0 = full combinational shift then one output register (latency 1 cycle).

Ports:
- clk  input  1  rising-edge clock
- rstN  input  1  asynchronous active-low reset
- inValid  input  1  input operation valid
- inReady  output  1  block accepts the operation this cycle
- inData  input  WIDTH  operand
- shAmt  input  AW  shift amount, 0..WIDTH-1
- shOp  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101..111 pass-through
- shBit  input  1  fill bit for SLL/SRL vacated positions
- outValid  output  1  result valid
- outReady  input  1  consumer accepts the result
- outData  output  WIDTH  result

Behaviour:
- One clock, asynchronous active-low reset. On rstN=0: every stage valid bit = 0, outValid = 0, outData = 0, all stage data and control registers cleared.
- Pipeline advance: adv = !outValid || outReady. inReady = adv (combinational). Transfer in occurs when inValid && inReady; transfer out occurs when outValid && outReady.
- When adv=1, every stage register loads from its predecessor, valid bits included; stage 0 loads inValid. When adv=0, the whole pipe holds, and outData/outValid stay stable.
- Bubbles are not compressed. Throughput is 1 op/cycle when outReady is held high.
- PIPE=1: stage k (k=0..AW-1) shifts by 2^k when shAmt[k]=1, otherwise passes through. shOp, shBit and the remaining amount bits travel with the data. Latency from input transfer to outValid = AW cycles.
- PIPE=0: all stages are combinational and only the output register is present. Latency = 1 cycle.
- SLL: vacated LSBs = shBit.
- SRL: vacated MSBs = shBit.
- SRA: vacated MSBs = inData[WIDTH-1]; shBit is ignored.
- ROL/ROR: bits wrap around; shBit is ignored.
- shAmt = 0: result = inData for every mode.
- Pass-through opcodes: result = inData regardless of shAmt.
- Shift amounts of WIDTH or more are not representable; AW bits bound the amount to WIDTH-1.
- Simultaneous transfer in and out while the pipe is full: both occur, with no loss or duplication.
- Reset asserted mid-operation: all in-flight operations are discarded. After release, the first output appears only for an operation accepted after reset.
- No combinational path from inData to outData.

Optional Feature:
- Macro: SHIFTER_FLAGS_EN.
- With the macro: adds outputs outZero (1) and outCarry (1), registered and aligned with outData/outValid, both reset to 0.
  - outZero = (outData == 0).
  - outCarry = last bit shifted out: SLL → inData[WIDTH-shAmt]; SRL/SRA → inData[shAmt-1]; ROL → result[0]; ROR → result[WIDTH-1].
  - outCarry = 0 when shAmt = 0 or the opcode is pass-through.
- Without the macro: the ports and their logic are absent, and behaviour is otherwise identical.

Test Plan:
- WIDTH=32, PIPE=1. Send inData=32'h1, shAmt=1, SLL, shBit=0, outReady=1 → outValid exactly 5 cycles after acceptance, outData=32'h2. Then shAmt=31 → 32'h80000000.
- SRA inData=32'h80000000, shAmt=4 → 32'hF8000000. SRL same operands with shBit=1 → 32'hF8000000. SRL with shBit=0 → 32'h08000000.
- ROR inData=32'h0000000F, shAmt=4 → 32'hF0000000. ROL inData=32'h80000001, shAmt=1 → 32'h00000003. Opcode 111 with shAmt=7 → inData unchanged.
- Backpressure: stream 8 back-to-back ops with incrementing inData and SLL shAmt=0. Hold outReady=0 for 3 cycles mid-stream → inReady=0 during the stall, outData stable, all 8 results delivered in order with none lost or duplicated.
- Reset mid-flight: accept 3 ops, pulse rstN low for 1 cycle (asynchronously, not clock-aligned) → outValid=0 and outData=0 immediately. No stale results appear afterwards. A new op returns after 5 cycles.
- PIPE=0, with SHIFTER_FLAGS_EN defined: SLL inData=32'h80000000, shAmt=1 → outData=0 after 1 cycle, outZero=1, outCarry=1. Same operands with shAmt=0 → outCarry=0, outZero=0.
